// File: rtl/decode_pkg.sv
// decode_pkg: opcode and ALU-op encodings plus the control half of the
// decoded bundle shared by the decode stage and its users.
package decode_pkg;

    // 5-bit instruction opcodes
    localparam logic [4:0] OPC_ADD  = 5'd0;
    localparam logic [4:0] OPC_SUB  = 5'd1;
    localparam logic [4:0] OPC_OR   = 5'd2;
    localparam logic [4:0] OPC_AND  = 5'd3;
    localparam logic [4:0] OPC_XOR  = 5'd4;
    localparam logic [4:0] OPC_SL   = 5'd5;
    localparam logic [4:0] OPC_SR   = 5'd6;
    localparam logic [4:0] OPC_ADDI = 5'd7;
    localparam logic [4:0] OPC_SRI  = 5'd13;
    localparam logic [4:0] OPC_GT   = 5'd14;
    localparam logic [4:0] OPC_LT   = 5'd15;
    localparam logic [4:0] OPC_EQ   = 5'd16;
    localparam logic [4:0] OPC_BR   = 5'd17;
    localparam logic [4:0] OPC_STW  = 5'd18;
    localparam logic [4:0] OPC_LDW  = 5'd19;

    // 4-bit ALU operations
    localparam logic [3:0] ALU_IDLE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SL   = 4'd6;
    localparam logic [3:0] ALU_SR   = 4'd7;
    localparam logic [3:0] ALU_GT   = 4'd8;
    localparam logic [3:0] ALU_LT   = 4'd9;
    localparam logic [3:0] ALU_EQ   = 4'd10;

    // Width-independent part of the decoded bundle
    typedef struct packed {
        logic [3:0] op;
        logic       immed;
        logic       wr_en;
        logic       is_br;
        logic       is_stw;
        logic       is_ldw;
        logic       illegal;
    } decode_ctrl_t;

    // Opcode -> control fields. Reg-reg and immediate forms share ALU ops;
    // GT/LT/EQ follow SR in the ALU numbering, so 7..16 map to opc-6.
    function automatic decode_ctrl_t decode_ctrl(input logic [4:0] opc);
        decode_ctrl_t c;
        c = '0;
        if (opc <= OPC_SR) begin
            c.op    = 4'(opc) + 4'd1;
            c.wr_en = 1'b1;
        end else if (opc <= OPC_SRI) begin
            c.op    = 4'(opc - 5'd6);
            c.immed = 1'b1;
            c.wr_en = 1'b1;
        end else if (opc <= OPC_EQ) begin
            c.op    = 4'(opc - 5'd6);
            c.wr_en = 1'b1;
        end else if (opc == OPC_BR) begin
            c.is_br = 1'b1;
        end else if (opc == OPC_STW) begin
            c.is_stw = 1'b1;
        end else if (opc == OPC_LDW) begin
            c.is_ldw = 1'b1;
            c.wr_en  = 1'b1;
        end else begin
            c.illegal = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/decode_if.sv
// decode_if: fetch-side, issue-side and writeback signals of the decode
// stage. master = environment driving instructions/writeback, slave = stage.
interface decode_if #(
    parameter int INSTR_W = 16,
    parameter int REG_AW  = 3,
    parameter int DATA_W  = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [INSTR_W-1:0]  in_instr;
    logic                out_valid;
    logic                out_ready;
    logic [3:0]          out_op;
    logic                out_immed;
    logic [DATA_W-1:0]   out_imm;
    logic [REG_AW-1:0]   out_regA;
    logic [REG_AW-1:0]   out_regB;
    logic [REG_AW-1:0]   out_regOut;
    logic                out_wr_en;
    logic                out_is_br;
    logic                out_is_stw;
    logic                out_is_ldw;
    logic                out_illegal;
    logic                wb_valid;
    logic [REG_AW-1:0]   wb_reg;

    modport master (
        output in_valid, in_instr, out_ready, wb_valid, wb_reg,
        input  in_ready, out_valid, out_op, out_immed, out_imm, out_regA,
               out_regB, out_regOut, out_wr_en, out_is_br, out_is_stw,
               out_is_ldw, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, out_ready, wb_valid, wb_reg,
        output in_ready, out_valid, out_op, out_immed, out_imm, out_regA,
               out_regB, out_regOut, out_wr_en, out_is_br, out_is_stw,
               out_is_ldw, out_illegal
    );
endinterface

// File: rtl/decode_scoreboard.sv
// decode_scoreboard: one pending bit per architectural register. A set and a
// clear of the same register in one cycle leaves it pending. The lookup
// output already reflects this cycle's clear so a waiting instruction can
// issue in the writeback cycle.
module decode_scoreboard #(
    parameter int REG_AW = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   set_en,
    input  logic [REG_AW-1:0]      set_reg,
    input  logic                   clr_en,
    input  logic [REG_AW-1:0]      clr_reg,
    output logic [(1<<REG_AW)-1:0] pending
);
    localparam int NREG = 1 << REG_AW;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_bit
            logic pending_reg;
            logic hit_set;
            logic hit_clr;

            assign hit_set = set_en && (set_reg == REG_AW'(gi));
            assign hit_clr = clr_en && (clr_reg == REG_AW'(gi));

            // Pending bit: set has priority over a same-cycle clear
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pending_reg <= 1'b0;
                end else if (hit_set) begin
                    pending_reg <= 1'b1;
                end else if (hit_clr) begin
                    pending_reg <= 1'b0;
                end
            end

            assign pending[gi] = pending_reg && !hit_clr;
        end
    endgenerate
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered, handshaked instruction decode. Optional register
// scoreboard enabled by defining DECODE_SCOREBOARD_EN; without it hazards are
// never raised and the writeback port is ignored.
module decode_stage
    import decode_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int REG_AW  = 3,
    parameter int DATA_W  = 16
) (
    input  logic     CLK,
    input  logic     reset,
    decode_if.slave  bus
);
    localparam int IMM_W = INSTR_W - 2*REG_AW - 5;

    // Raw fields of the incoming instruction
    logic [4:0]        opc;
    logic [REG_AW-1:0] f_reg_out;
    logic [REG_AW-1:0] f_reg_a;
    logic [REG_AW-1:0] f_reg_b;
    logic [IMM_W-1:0]  f_imm;
    decode_ctrl_t      ctrl;
    logic [DATA_W-1:0] dec_imm;
    logic [REG_AW-1:0] dec_reg_b;

    assign opc       = bus.in_instr[4:0];
    assign f_reg_out = bus.in_instr[INSTR_W-1 -: REG_AW];
    assign f_reg_a   = bus.in_instr[INSTR_W-REG_AW-1 -: REG_AW];
    assign f_reg_b   = bus.in_instr[INSTR_W-2*REG_AW-1 -: REG_AW];
    assign f_imm     = bus.in_instr[INSTR_W-2*REG_AW-1 : 5];
    assign ctrl      = decode_ctrl(opc);
    assign dec_imm   = ctrl.immed ? DATA_W'($signed(f_imm)) : '0;
    assign dec_reg_b = ctrl.immed ? '0 : f_reg_b;

    // Output bundle registers
    logic              out_valid_reg;
    decode_ctrl_t      out_ctrl_reg;
    logic [DATA_W-1:0] out_imm_reg;
    logic [REG_AW-1:0] out_reg_a_reg;
    logic [REG_AW-1:0] out_reg_b_reg;
    logic [REG_AW-1:0] out_reg_out_reg;

    logic hazard;
    logic in_ready;
    logic accept;
    logic out_fire;

    assign out_fire = out_valid_reg && bus.out_ready;
    assign in_ready = !reset && (!out_valid_reg || bus.out_ready) && !hazard;
    assign accept   = bus.in_valid && in_ready;

`ifdef DECODE_SCOREBOARD_EN
    logic [(1<<REG_AW)-1:0] pending;
    logic                   inflight_wr;

    decode_scoreboard #(
        .REG_AW (REG_AW)
    ) u_scoreboard (
        .clk     (CLK),
        .rst     (reset),
        .set_en  (out_fire && out_ctrl_reg.wr_en),
        .set_reg (out_reg_out_reg),
        .clr_en  (bus.wb_valid),
        .clr_reg (bus.wb_reg),
        .pending (pending)
    );

    // The bundle sitting in the output register is not yet in the
    // scoreboard (it is marked on handoff), so its destination is checked
    // directly, even while it is being handed off this cycle.
    assign inflight_wr = out_valid_reg && out_ctrl_reg.wr_en;

    // Hazard: any source or written destination still pending or in flight
    always_comb begin
        hazard = pending[f_reg_a] || (inflight_wr && out_reg_out_reg == f_reg_a);
        if (!ctrl.immed) begin
            hazard = hazard || pending[f_reg_b]
                   || (inflight_wr && out_reg_out_reg == f_reg_b);
        end
        if (ctrl.is_stw || ctrl.wr_en) begin
            hazard = hazard || pending[f_reg_out]
                   || (inflight_wr && out_reg_out_reg == f_reg_out);
        end
    end
`else
    logic unused_wb;
    assign unused_wb = ^{bus.wb_valid, bus.wb_reg};
    assign hazard    = 1'b0;
`endif

    // Load a new bundle on accept, otherwise drop valid once handed off
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            out_valid_reg   <= 1'b0;
            out_ctrl_reg    <= '0;
            out_imm_reg     <= '0;
            out_reg_a_reg   <= '0;
            out_reg_b_reg   <= '0;
            out_reg_out_reg <= '0;
        end else if (accept) begin
            out_valid_reg   <= 1'b1;
            out_ctrl_reg    <= ctrl;
            out_imm_reg     <= dec_imm;
            out_reg_a_reg   <= f_reg_a;
            out_reg_b_reg   <= dec_reg_b;
            out_reg_out_reg <= f_reg_out;
        end else if (out_fire) begin
            out_valid_reg   <= 1'b0;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_reg;
    assign bus.out_op      = out_ctrl_reg.op;
    assign bus.out_immed   = out_ctrl_reg.immed;
    assign bus.out_imm     = out_imm_reg;
    assign bus.out_regA    = out_reg_a_reg;
    assign bus.out_regB    = out_reg_b_reg;
    assign bus.out_regOut  = out_reg_out_reg;
    assign bus.out_wr_en   = out_ctrl_reg.wr_en;
    assign bus.out_is_br   = out_ctrl_reg.is_br;
    assign bus.out_is_stw  = out_ctrl_reg.is_stw;
    assign bus.out_is_ldw  = out_ctrl_reg.is_ldw;
    assign bus.out_illegal = out_ctrl_reg.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios plus randomized traffic, checked every
// cycle against a behavioural model of the decode stage (opcode table,
// pending-register set, single-entry output slot).
module tb_decode_stage;

    typedef struct packed {
        logic [3:0]  op;
        logic        immed;
        logic [15:0] imm;
        logic [2:0]  rega;
        logic [2:0]  regb;
        logic [2:0]  rego;
        logic        wr;
        logic        br;
        logic        stw;
        logic        ldw;
        logic        ill;
    } bundle_t;

    logic CLK;
    logic reset;

    decode_if #(.INSTR_W(16), .REG_AW(3), .DATA_W(16)) bus ();

    decode_stage #(.INSTR_W(16), .REG_AW(3), .DATA_W(16)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cmp_count = 0;
    int err_count = 0;

    // model state
    bit      m_valid;
    bundle_t m_b;
    bit      m_pend [8];
    bit      m_ready;
    bit      last_in_ready;

    localparam logic [15:0] I_ADDI = 16'h47A7; // ADDI r2,r1,-3
    localparam logic [15:0] I_ILL  = 16'h0016; // opcode 22
    localparam logic [15:0] I_ADD  = 16'h6500; // ADD r3,r1,r2
    localparam logic [15:0] I_SUB  = 16'h8C81; // SUB r4,r3,r1
    localparam logic [15:0] I_ADDX = 16'hB827; // ADDI r5,r6,1

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        cmp_count++;
        if (act !== req) begin
            err_count++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic bundle_t model_decode(input logic [15:0] w);
        bundle_t b;
        int opc;
        int iv;
        opc = int'(w[4:0]);
        b = '0;
        b.rego = w[15:13];
        b.rega = w[12:10];
        b.immed = (opc >= 7 && opc <= 13);
        if (opc <= 6)       b.op = 4'(opc + 1);
        else if (opc <= 16) b.op = 4'(opc - 6);
        else                b.op = 4'd0;
        b.wr  = (opc <= 16) || (opc == 19);
        b.br  = (opc == 17);
        b.stw = (opc == 18);
        b.ldw = (opc == 19);
        b.ill = (opc >= 20);
        b.regb = b.immed ? 3'd0 : w[9:7];
        iv = int'(w[9:5]);
        if (iv >= 16) iv = iv - 32;
        b.imm = b.immed ? 16'(iv) : 16'd0;
        return b;
    endfunction

    function automatic bit model_hazard(input logic [15:0] w, input logic wbv, input logic [2:0] wbr);
        bit h;
        h = 0;
`ifdef DECODE_SCOREBOARD_EN
        begin
            bundle_t d;
            int regs[$];
            d = model_decode(w);
            regs.push_back(int'(w[12:10]));
            if (!d.immed) regs.push_back(int'(w[9:7]));
            if (d.stw || d.wr) regs.push_back(int'(w[15:13]));
            foreach (regs[k]) begin
                if (m_pend[regs[k]] && !(wbv && int'(wbr) == regs[k])) h = 1;
                if (m_valid && m_b.wr && int'(m_b.rego) == regs[k]) h = 1;
            end
        end
`else
        if (wbv && wbr == 3'd7 && w == 16'hFFFF) h = 0;
`endif
        return h;
    endfunction

    // One clock: drive at negedge, compare, advance model, return after posedge
    task automatic step(input logic v, input logic [15:0] ins, input logic ordy,
                        input logic wbv, input logic [2:0] wbr, input logic r);
        bundle_t act;
        bit fire;
        bit acc;
        @(negedge CLK);
        reset         = r;
        bus.in_valid  = v;
        bus.in_instr  = ins;
        bus.out_ready = ordy;
        bus.wb_valid  = wbv;
        bus.wb_reg    = wbr;
        #1;
        if (r) begin
            m_valid = 0;
            foreach (m_pend[k]) m_pend[k] = 0;
        end
        m_ready = !r && (!m_valid || ordy) && !model_hazard(ins, wbv, wbr);
        act = {bus.out_op, bus.out_immed, bus.out_imm, bus.out_regA, bus.out_regB,
               bus.out_regOut, bus.out_wr_en, bus.out_is_br, bus.out_is_stw,
               bus.out_is_ldw, bus.out_illegal};
        last_in_ready = bus.in_ready;
        check("in_ready", 64'(bus.in_ready), 64'(m_ready));
        check("out_valid", 64'(bus.out_valid), 64'(m_valid));
        if (r)            check("reset_bundle", 64'(act), 64'd0);
        else if (m_valid) check("bundle", 64'(act), 64'(m_b));
        if (!r) begin
            fire = m_valid && ordy;
            acc  = v && m_ready;
            if (wbv) m_pend[wbr] = 0;
            if (fire && m_b.wr) m_pend[m_b.rego] = 1;
            if (acc) begin
                m_b = model_decode(ins);
                m_valid = 1;
            end else if (fire) begin
                m_valid = 0;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        w = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 5'($urandom_range(0, 31))};
        return w;
    endfunction

    bit exp_sb;

    initial begin
`ifdef DECODE_SCOREBOARD_EN
        exp_sb = 1;
`else
        exp_sb = 0;
`endif
        reset = 1'b1;
        bus.in_valid = 0; bus.in_instr = '0; bus.out_ready = 0;
        bus.wb_valid = 0; bus.wb_reg = '0;
        m_valid = 0;
        m_b = '0;
        foreach (m_pend[k]) m_pend[k] = 0;

        // reset state
        step(0, 16'h0, 0, 0, 3'd0, 1);
        step(0, 16'h0, 0, 0, 3'd0, 1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(last_in_ready), 64'd0);

        // ADDI r2,r1,-3
        step(1, I_ADDI, 0, 0, 3'd0, 0);
        check("addi_accept", 64'(last_in_ready), 64'd1);
        check("addi_op", 64'(bus.out_op), 64'd1);
        check("addi_immed", 64'(bus.out_immed), 64'd1);
        check("addi_imm", 64'(bus.out_imm), 64'hFFFD);
        check("addi_regs", 64'({bus.out_regOut, bus.out_regA, bus.out_regB}), 64'({3'd2, 3'd1, 3'd0}));
        check("addi_wr", 64'(bus.out_wr_en), 64'd1);

        // illegal opcode, then retire it and write back r2
        step(1, I_ILL, 1, 0, 3'd0, 0);
        check("ill_flag", 64'(bus.out_illegal), 64'd1);
        check("ill_op", 64'(bus.out_op), 64'd0);
        check("ill_wr", 64'(bus.out_wr_en), 64'd0);
        step(0, 16'h0, 1, 1, 3'd2, 0);

        // RAW: ADD r3,r1,r2 then SUB r4,r3,r1
        step(1, I_ADD, 1, 0, 3'd0, 0);
        step(1, I_SUB, 1, 0, 3'd0, 0);
        check("raw_first", 64'(last_in_ready), exp_sb ? 64'd0 : 64'd1);
        if (exp_sb) begin
            step(1, I_SUB, 1, 0, 3'd0, 0);
            check("raw_wait", 64'(last_in_ready), 64'd0);
            step(1, I_SUB, 1, 1, 3'd3, 0);
            check("raw_wb_accept", 64'(last_in_ready), 64'd1);
        end
        check("sub_op", 64'(bus.out_op), 64'd2);
        check("sub_dst", 64'(bus.out_regOut), 64'd4);

        // backpressure for 4 cycles
        for (int i = 0; i < 4; i++) begin
            step(1, I_ADDX, 0, 0, 3'd0, 0);
            check("bp_in_ready", 64'(last_in_ready), 64'd0);
            check("bp_hold", 64'({bus.out_valid, bus.out_op, bus.out_regOut}), 64'({1'b1, 4'd2, 3'd4}));
        end
        step(1, I_ADDX, 1, 0, 3'd0, 0);
        check("bp_release", 64'(last_in_ready), 64'd1);
        check("bp_new", 64'({bus.out_valid, bus.out_regOut, bus.out_imm}), 64'({1'b1, 3'd5, 16'd1}));

        // reset in the middle of a stall with r3 pending
        step(1, I_ADD, 1, 0, 3'd0, 0);
        step(1, I_SUB, 1, 0, 3'd0, 0);
        step(1, I_SUB, 0, 0, 3'd0, 1);
        check("midrst_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_ready", 64'(last_in_ready), 64'd0);
        step(1, I_SUB, 1, 0, 3'd0, 0);
        check("postrst_accept", 64'(last_in_ready), 64'd1);
        check("postrst_op", 64'({bus.out_valid, bus.out_op}), 64'({1'b1, 4'd2}));

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0, 3'($urandom_range(0, 3)),
                 $urandom_range(0, 299) == 0);
        end
        // drain
        for (int i = 0; i < 4; i++) step(0, 16'h0, 1, 1, 3'(i), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, handshaked instruction-decode stage for the FPGA CPU, parametrised in instruction width, register-address width and data width. Accepts raw instruction words from fetch, decodes opcode and register fields, and presents a registered decoded bundle to the ALU/issue stage. An optional register scoreboard stalls issue on RAW/WAW hazards until writeback clears the pending register.

## Interface
Parameters:
- INSTR_W, 16, instruction word width (≥ 5 + 3·REG_AW + 1)
- REG_AW, 3, register-address width (2^REG_AW registers)
- DATA_W, 16, width of the sign-extended immediate

Ports:
- CLK  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  fetch presents in_instr
- in_ready  out  1  decode accepts in_instr this cycle
- in_instr  in  INSTR_W  raw instruction
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts bundle
- out_op  out  4  ALU op (IDLE=0, ADD=1, SUB=2, OR=3, AND=4, XOR=5, SL=6, SR=7, GT=8, LT=9, EQ=10)
- out_immed  out  1  operand B is out_imm
- out_imm  out  DATA_W  sign-extended immediate (0 if !out_immed)
- out_regA / out_regB / out_regOut  out  REG_AW each  register indices (out_regB = 0 when out_immed)
- out_wr_en  out  1  instruction writes out_regOut
- out_is_br / out_is_stw / out_is_ldw  out  1 each  class flags
- out_illegal  out  1  undefined opcode
- wb_valid  in  1  writeback completing
- wb_reg  in  REG_AW  register being written back

## Operation
- Fields: opcode = instr[4:0]; regOut = instr[INSTR_W-1 -: REG_AW]; regA = next REG_AW bits below; regB = next REG_AW below that; imm = instr[INSTR_W-2·REG_AW-1 : 5], sign-extended to DATA_W.
- Opcodes 0–6: ADD,SUB,OR,AND,XOR,SL,SR (reg-reg). 7–13: ADDI..SRI (same ops, immed=1). 14 GT, 15 LT, 16 EQ. 17 BR, 18 STW, 19 LDW → op=IDLE.
- out_wr_en = 1 for opcodes 0–16 and LDW; 0 for BR, STW, illegal.
- Opcodes 20–31: out_illegal=1, op=IDLE, all class flags and wr_en 0; still passed downstream.
- Source set: regA always; regB when !immed; regOut additionally for STW (store data).
- Hazard (scoreboard builds only): any source or, if wr_en, the destination has its pending bit set, after applying this cycle's wb clear; or out stage holds a valid, not-yet-accepted bundle with out_wr_en whose out_regOut matches a source/destination.
- in_ready = !reset && (!out_valid || out_ready) && !hazard.
- Accept (in_valid && in_ready): bundle loaded into output register, out_valid=1.
- Scoreboard set on output handshake (out_valid && out_ready && out_wr_en) for out_regOut; clear on wb_valid for wb_reg. Same register set and cleared same cycle: set wins.
- in_valid may drop without acceptance; no penalty.

## Timing
- Latency: 1 cycle from accepted in_instr to out_valid.
- Throughput: 1 instr/cycle absent hazards and backpressure; accept and output handshake allowed same cycle.
- Output bundle held stable while out_valid && !out_ready.
- wb clear bypasses combinationally into hazard check: a waiting instruction is accepted in the wb cycle.
- Reset (any time, including mid-stall): out_valid=0, all outputs 0, scoreboard all-zero, in_ready=0 while asserted; in-flight bundle dropped.

## Configuration
- DECODE_SCOREBOARD_EN defined: scoreboard and hazard logic present as above.
- Undefined: no scoreboard; hazard ≡ 0; wb_valid/wb_reg ignored; in_ready = !reset && (!out_valid || out_ready).

## Structure
- Package decode_pkg: opcode constants (5-bit), ALU op constants (4-bit), decoded-bundle struct typedef.
- Sub-module decode_scoreboard: 2^REG_AW pending bits, set/clear ports, combinational pending-lookup with wb bypass; instantiated only under DECODE_SCOREBOARD_EN.

## Test plan
- ADDI r2,r1,-3 (16-bit, imm field 5'b11101) → next cycle out_op=1, out_immed=1, out_imm=16'hFFFD, regOut=2, regA=1, regB=0, wr_en=1.
- Opcode 5'b10110 → out_illegal=1, out_op=0, wr_en=0, scoreboard unchanged.
- Back-to-back ADD r3,r1,r2 then SUB r4,r3,r1 with scoreboard: second stalls (in_ready=0) until wb_valid wb_reg=3; accepted same cycle as wb.
- Same pair without DECODE_SCOREBOARD_EN: both accepted consecutive cycles.
- out_ready=0 for 4 cycles with valid bundle: bundle stable, in_ready=0; out_ready=1 with new in_valid → handoff and new accept same cycle.
- reset asserted mid-stall with pending r3: out_valid=0 immediately, scoreboard clear; after release the stalled SUB is accepted first cycle.
